acc_seq: RTL and testbench

- Sequencing and storage stage directly downstream of the 9-way ALU result multiplexer in the accumulator datapath.
- Accepts instructions (opcode + operand) over a valid/ready handshake, drives the ALU/mux select and operands, then latches the selected result into the accumulator register.
- Produces status flags, a completion pulse and an instruction count for the display/test logic.

---
 rtl/acc_pkg.sv | 29 ++
 rtl/acc_seq.sv | 102 ++++++++++
 tb/tb_acc_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared constants and types for the accumulator sequencer.
// Opcodes match the select encoding of the downstream 9-way result mux.
package acc_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_BUF = 4'd8;
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes 9..14 select the mux default (zero) and are flagged invalid.
    function automatic logic op_is_invalid(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/acc_seq.sv
// Accumulator sequencer: accepts one instruction, drives the external ALU/mux,
// and latches its result into acc with status flags, a done pulse and a count.
module acc_seq
    import acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [WIDTH-1:0] instr_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_inv,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state, state_nx;
    logic             accept;
    logic             retire;
    logic             op_inv;
    logic             op_nop;
    logic [WIDTH-1:0] acc_nx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid) state_nx = EXEC;
            end
            EXEC: begin
                retire   = 1'b1;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        op_inv = op_is_invalid(alu_op);
        op_nop = (alu_op == OP_NOP);
        acc_nx = acc;
        if (op_inv)       acc_nx = '0;
        else if (!op_nop) acc_nx = alu_result;
    end

    assign alu_a = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_inv  <= 1'b0;
            done      <= 1'b0;
            instr_cnt <= '0;
        end else begin
            done <= retire;
            if (accept) begin
                alu_op <= instr_op;
                alu_b  <= instr_operand;
            end
            if (retire) begin
                acc       <= acc_nx;
                instr_cnt <= instr_cnt + 1'b1;
                // A NOP retires and is counted but leaves every flag untouched.
                if (!op_nop) begin
                    flag_inv <= op_inv;
                    flag_z   <= (acc_nx == '0);
                    flag_n   <= acc_nx[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq with a behavioural ALU/mux in the loop and an
// arithmetic reference model of the accumulator, flags and counter.
module tb_acc_seq;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [3:0]       instr_op = '0;
    logic [WIDTH-1:0] instr_operand = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result, acc;
    logic [3:0]       alu_op;
    logic             flag_z, flag_n, flag_inv, done;
    logic [CNT_W-1:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [WIDTH-1:0] m_acc;
    logic             m_z, m_n, m_inv;
    int               m_cnt;

    always #5 clk = ~clk;

    acc_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_operand(instr_operand),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .acc          (acc),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_inv     (flag_inv),
        .done         (done),
        .instr_cnt    (instr_cnt)
    );

    // external ALU + 9-way mux; shifts are by one position, shr is arithmetic
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = ~alu_a;
            4'd6: alu_result = alu_a << 1;
            4'd7: alu_result = $signed(alu_a) >>> 1;
            4'd8: alu_result = alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = 0;
        case (op)
            4'd0: r = sa + sb;
            4'd1: r = sa - sb;
            4'd2: r = int'(a & b);
            4'd3: r = int'(a | b);
            4'd4: r = int'(a ^ b);
            4'd5: r = -sa - 1;
            4'd6: r = sa * 2;
            4'd7: r = (sa < 0) ? (sa - 1) / 2 : sa / 2;
            4'd8: r = sb;
            default: r = 0;
        endcase
        return r[WIDTH-1:0];
    endfunction

    task automatic model_reset();
        m_acc = '0; m_z = 0; m_n = 0; m_inv = 0; m_cnt = 0;
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [WIDTH-1:0] b);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (op == 4'd15) return;
        if (op >= 4'd9) begin
            m_acc = '0;
            m_inv = 1'b1;
        end else begin
            m_acc = ref_result(op, m_acc, b);
            m_inv = 1'b0;
        end
        m_z = (m_acc == 0);
        m_n = m_acc[WIDTH-1];
    endtask

    task automatic check_state(input string tag);
        check({tag, ".acc"},  int'(acc),       int'(m_acc));
        check({tag, ".z"},    int'(flag_z),    int'(m_z));
        check({tag, ".n"},    int'(flag_n),    int'(m_n));
        check({tag, ".inv"},  int'(flag_inv),  int'(m_inv));
        check({tag, ".cnt"},  int'(instr_cnt), m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // waits (bounded) at a falling edge until the block is ready
    task automatic wait_ready();
        int k = 0;
        while (!instr_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) check("ready_timeout", 0, 1);
    endtask

    // one full instruction, checking the handshake and outputs at each step
    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] prev_acc;
        wait_ready();
        prev_acc      = m_acc;
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_operand = b;
        model_apply(op, b);
        @(negedge clk);
        instr_valid   = 1'b0;
        instr_op      = 4'($urandom);
        instr_operand = WIDTH'($urandom);
        check({tag, ".exec_ready"}, int'(instr_ready), 0);
        check({tag, ".exec_done"},  int'(done),        0);
        check({tag, ".alu_op"},     int'(alu_op),      int'(op));
        check({tag, ".alu_b"},      int'(alu_b),       int'(b));
        check({tag, ".alu_a"},      int'(alu_a),       int'(prev_acc));
        @(negedge clk);
        check({tag, ".done"},       int'(done),        1);
        check({tag, ".done_ready"}, int'(instr_ready), 0);
        check_state(tag);
        @(negedge clk);
        check({tag, ".done_clr"},   int'(done),        0);
        check({tag, ".idle_ready"}, int'(instr_ready), 1);
    endtask

    initial begin
        int accepts, dones;
        logic [3:0] op;
        logic [WIDTH-1:0] b;

        // 1. reset
        do_reset();
        check("rst.ready", int'(instr_ready), 1);
        check("rst.done",  int'(done),        0);
        check_state("rst");

        // 2. load, add and wrap
        run_instr("ld_m5", 4'd8, 4'b1011);
        check("ld_m5.acc_const", int'(acc), 4'b1011);
        run_instr("ld_7", 4'd8, 4'd7);
        run_instr("add_wrap", 4'd0, 4'd1);
        check("add_wrap.acc_const", int'(acc), 4'b1000);
        check("add_wrap.cnt_const", int'(instr_cnt), 3);

        // 3. subtract to zero
        run_instr("ld_3", 4'd8, 4'd3);
        run_instr("sub_zero", 4'd1, 4'd3);
        check("sub_zero.z_const", int'(flag_z), 1);

        // 4. invalid then NOP
        run_instr("ld_5", 4'd8, 4'd5);
        run_instr("inv12", 4'd12, 4'd6);
        check("inv12.inv_const", int'(flag_inv), 1);
        run_instr("nop", 4'd15, 4'd9);

        // 5. back-pressure: valid held with operands changing every cycle
        accepts = 0;
        dones   = 0;
        for (int i = 0; i < 9; i++) begin
            if (done) dones++;
            op = ($urandom_range(0, 9) == 9) ? 4'd15 : 4'($urandom_range(0, 8));
            b  = WIDTH'($urandom);
            instr_valid   = 1'b1;
            instr_op      = op;
            instr_operand = b;
            if (instr_ready) begin
                accepts++;
                model_apply(op, b);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("bp.accepts", accepts, 3);
        check("bp.dones", dones, 3);
        check_state("bp");

        // random instruction stream including invalid opcodes and NOPs
        for (int i = 0; i < 40; i++)
            run_instr("rnd", 4'($urandom), WIDTH'($urandom));

        // 6. reset during EXEC
        do_reset();
        run_instr("ld_4", 4'd8, 4'd4);
        instr_valid   = 1'b1;
        instr_op      = 4'd0;
        instr_operand = 4'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        check("mid.in_exec", int'(instr_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid.done", int'(done), 0);
        check("mid.ready", int'(instr_ready), 1);
        check_state("mid");
        @(negedge clk);
        check("mid.done_after", int'(done), 0);
        check("mid.cnt_after", int'(instr_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
